// File: rtl/ped_min_select.sv
// Survivor selector for one sphere-decoder tree level: accumulates parent + PED,
// prunes against the sphere radius and tracks the best child and survivor count.
`timescale 1ns/1ps
module ped_min_select #(
   parameter int INT_W  = 6,
   parameter int FRAC_W = 10,
   parameter int WIDTH  = INT_W + FRAC_W,
   parameter int NCAND  = 8,
   parameter int IDX_W  = 3,
   parameter int CNT_W  = IDX_W + 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_parent_dist,
   input  logic [WIDTH-1:0]   i_radius,
   input  logic               i_valid,
   input  logic [WIDTH*2-1:0] i_ped,
   input  logic               i_last,
   output logic               o_busy,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_best_idx,
   output logic [WIDTH-1:0]   o_best_dist,
   output logic [CNT_W-1:0]   o_count,
   output logic               o_found
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCAND - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   parent_q, parent_d;
   logic [WIDTH-1:0]   radius_q, radius_d;
   logic [WIDTH-1:0]   best_dist_q, best_dist_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]   res_idx_q, res_idx_d;
   logic [WIDTH-1:0]   res_dist_q, res_dist_d;
   logic [CNT_W-1:0]   res_count_q, res_count_d;
   logic               res_found_q, res_found_d;

   logic [WIDTH:0]     sum_full;
   logic [WIDTH-1:0]   total;
   logic [WIDTH-1:0]   unused_ped_hi;

   assign unused_ped_hi = i_ped[WIDTH*2-1:WIDTH];

   // One guard bit catches overflow; saturate rather than wrap so an
   // overflowed path can never look like a small distance.
   assign sum_full = {1'b0, parent_q} + {1'b0, i_ped[WIDTH-1:0]};
   assign total    = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];

   always_comb begin
      state_d     = state_q;
      parent_d    = parent_q;
      radius_d    = radius_q;
      best_dist_d = best_dist_q;
      best_idx_d  = best_idx_q;
      idx_d       = idx_q;
      count_d     = count_q;
      res_idx_d   = res_idx_q;
      res_dist_d  = res_dist_q;
      res_count_d = res_count_q;
      res_found_d = res_found_q;

      if (i_start) begin
         parent_d    = i_parent_dist;
         radius_d    = i_radius;
         best_dist_d = '1;
         best_idx_d  = '0;
         idx_d       = '0;
         count_d     = '0;
         state_d     = S_COLLECT;
      end else begin
         case (state_q)
            S_COLLECT: begin
               if (i_valid) begin
                  if (total < radius_q) begin
                     count_d = count_q + CNT_W'(1);
                  end
                  if (total < best_dist_q) begin
                     best_dist_d = total;
                     best_idx_d  = idx_q;
                  end
                  idx_d = idx_q + IDX_W'(1);
                  // Results include the candidate accepted on this edge.
                  if (i_last || (idx_q == LAST_IDX)) begin
                     state_d     = S_DONE;
                     res_idx_d   = best_idx_d;
                     res_dist_d  = best_dist_d;
                     res_count_d = count_d;
                     res_found_d = (count_d != '0);
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         parent_q    <= '0;
         radius_q    <= '0;
         best_dist_q <= '0;
         best_idx_q  <= '0;
         idx_q       <= '0;
         count_q     <= '0;
         res_idx_q   <= '0;
         res_dist_q  <= '0;
         res_count_q <= '0;
         res_found_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         parent_q    <= parent_d;
         radius_q    <= radius_d;
         best_dist_q <= best_dist_d;
         best_idx_q  <= best_idx_d;
         idx_q       <= idx_d;
         count_q     <= count_d;
         res_idx_q   <= res_idx_d;
         res_dist_q  <= res_dist_d;
         res_count_q <= res_count_d;
         res_found_q <= res_found_d;
      end
   end

   assign o_busy      = (state_q == S_COLLECT);
   assign o_valid     = (state_q == S_DONE);
   assign o_best_idx  = res_idx_q;
   assign o_best_dist = res_dist_q;
   assign o_count     = res_count_q;
   assign o_found     = res_found_q;

endmodule

// File: tb/tb_ped_min_select.sv
// Randomized plus directed bench for ped_min_select against a per-level
// reference model computed from the collected candidate list.
`timescale 1ns/1ps
module tb_ped_min_select;

   localparam int WIDTH = 16;
   localparam int NCAND = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 4;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic               i_start;
   logic [WIDTH-1:0]   i_parent_dist;
   logic [WIDTH-1:0]   i_radius;
   logic               i_valid;
   logic [WIDTH*2-1:0] i_ped;
   logic               i_last;
   logic               o_busy;
   logic               o_valid;
   logic [IDX_W-1:0]   o_best_idx;
   logic [WIDTH-1:0]   o_best_dist;
   logic [CNT_W-1:0]   o_count;
   logic               o_found;

   int checks   = 0;
   int failures = 0;
   int last_idx, last_dist, last_cnt;

   ped_min_select #(
      .INT_W (6),
      .FRAC_W(10),
      .NCAND (NCAND),
      .IDX_W (IDX_W)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_parent_dist(i_parent_dist),
      .i_radius     (i_radius),
      .i_valid      (i_valid),
      .i_ped        (i_ped),
      .i_last       (i_last),
      .o_busy       (o_busy),
      .o_valid      (o_valid),
      .o_best_idx   (o_best_idx),
      .o_best_dist  (o_best_dist),
      .o_count      (o_count),
      .o_found      (o_found)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Reference: saturating totals, strict-less pruning, first minimum wins,
   // only the first NCAND candidates of a level count.
   task automatic ref_model(input logic [15:0] par, input logic [15:0] rad,
                            input logic [15:0] peds[$],
                            output int bidx, output int bdist, output int cnt);
      int lim;
      int t;
      lim   = (peds.size() > NCAND) ? NCAND : peds.size();
      bdist = 32'hFFFF;
      bidx  = 0;
      cnt   = 0;
      for (int k = 0; k < lim; k++) begin
         t = int'(par) + int'(peds[k]);
         if (t > 32'hFFFF) t = 32'hFFFF;
         if (t < int'(rad)) cnt++;
         if (t < bdist) begin
            bdist = t;
            bidx  = k;
         end
      end
   endtask

   task automatic check_results(input string tag);
      chk({tag, ".valid"}, o_valid, 1);
      chk({tag, ".busy"}, o_busy, 0);
      chk({tag, ".idx"}, o_best_idx, last_idx);
      chk({tag, ".dist"}, o_best_dist, last_dist);
      chk({tag, ".count"}, o_count, last_cnt);
      chk({tag, ".found"}, o_found, (last_cnt != 0) ? 1 : 0);
   endtask

   // Starts a level, streams the candidates (optionally with gaps) and checks
   // the DONE cycle. Leaves the DUT sitting in DONE.
   task automatic run_level(input string tag, input logic [15:0] par, input logic [15:0] rad,
                            input logic [15:0] peds[$], input bit use_last,
                            input int gap_pct, input bit valid_on_start);
      int n;
      n = peds.size();
      i_start       = 1'b1;
      i_parent_dist = par;
      i_radius      = rad;
      i_valid       = valid_on_start;
      i_ped         = {16'($urandom), 16'h0000};
      i_last        = valid_on_start;
      tick();
      i_start = 1'b0;
      i_valid = 1'b0;
      i_last  = 1'b0;
      chk({tag, ".start_busy"}, o_busy, 1);
      chk({tag, ".start_valid"}, o_valid, 0);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(99) < gap_pct) begin
            i_valid = 1'b0;
            tick();
            chk({tag, ".gap_busy"}, o_busy, 1);
         end
         i_valid = 1'b1;
         i_ped   = {16'($urandom), peds[k]};
         i_last  = use_last && (k == n - 1);
         tick();
         if (k < n - 1) chk({tag, ".mid_valid"}, o_valid, 0);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      ref_model(par, rad, peds, last_idx, last_dist, last_cnt);
      check_results(tag);
   endtask

   initial begin
      logic [15:0] q[$];
      logic [15:0] par, rad;
      int n;
      bit use_last;

      i_rst = 1'b1; i_start = 1'b0; i_parent_dist = '0; i_radius = '0;
      i_valid = 1'b0; i_ped = '0; i_last = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      tick();
      chk("rst.busy", o_busy, 0);
      chk("rst.valid", o_valid, 0);
      chk("rst.idx", o_best_idx, 0);
      chk("rst.dist", o_best_dist, 0);
      chk("rst.count", o_count, 0);
      chk("rst.found", o_found, 0);

      // Valid while idle must not start anything.
      i_valid = 1'b1; i_ped = 32'h0000_0100; i_last = 1'b1;
      tick();
      i_valid = 1'b0; i_last = 1'b0;
      tick();
      chk("idle.valid", o_valid, 0);
      chk("idle.busy", o_busy, 0);

      // 1. Basic level
      q = '{16'h0800, 16'h0200, 16'h0C00, 16'h0200};
      run_level("basic", 16'h0400, 16'h1000, q, 1, 0, 0);
      chk("basic.spec_idx", o_best_idx, 1);
      chk("basic.spec_dist", o_best_dist, 16'h0600);
      chk("basic.spec_count", o_count, 3);
      tick();
      chk("basic.hold_valid", o_valid, 0);
      chk("basic.hold_dist", o_best_dist, 16'h0600);

      // 2. No survivors
      q = '{16'h0300, 16'h0200};
      run_level("nosurv", 16'h0000, 16'h0100, q, 1, 0, 0);
      chk("nosurv.spec_found", o_found, 0);
      tick();

      // 3. Saturation
      q = '{16'h2000};
      run_level("sat", 16'hF000, 16'hFFFF, q, 1, 0, 0);
      chk("sat.spec_dist", o_best_dist, 16'hFFFF);
      tick();

      // 4. Auto-terminate; the 9th valid lands in DONE and must be ignored
      q = '{16'h0800, 16'h0700, 16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100};
      run_level("auto", 16'h0000, 16'h0500, q, 0, 0, 0);
      chk("auto.spec_idx", o_best_idx, 7);
      chk("auto.spec_count", o_count, 4);
      i_valid = 1'b1; i_ped = 32'h0000_0010; i_last = 1'b1;
      tick();
      i_valid = 1'b0; i_last = 1'b0;
      chk("auto.ninth_valid", o_valid, 0);
      chk("auto.ninth_busy", o_busy, 0);
      chk("auto.ninth_dist", o_best_dist, 16'h0100);
      tick();
      chk("auto.ninth_late", o_valid, 0);

      // 5. Gaps then asynchronous reset mid-level
      i_start = 1'b1; i_parent_dist = 16'h0100; i_radius = 16'h2000;
      tick();
      i_start = 1'b0;
      i_valid = 1'b1; i_ped = 32'h0000_0050; tick();
      i_valid = 1'b0; tick(); tick();
      i_valid = 1'b1; i_ped = 32'h0000_0040; tick();
      i_valid = 1'b0;
      chk("rst_mid.busy_before", o_busy, 1);
      #2 i_rst = 1'b1;
      #1;
      chk("rst_mid.busy", o_busy, 0);
      chk("rst_mid.valid", o_valid, 0);
      chk("rst_mid.idx", o_best_idx, 0);
      chk("rst_mid.dist", o_best_dist, 0);
      chk("rst_mid.count", o_count, 0);
      chk("rst_mid.found", o_found, 0);
      tick();
      i_rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_valid = 1'b1; i_ped = 32'h0000_0001; i_last = 1'b1;
         tick();
         chk("rst_mid.after_valid", o_valid, 0);
      end
      i_valid = 1'b0; i_last = 1'b0;

      // 6. Mid-level restart (with a valid coinciding with the restart)
      i_start = 1'b1; i_parent_dist = 16'h0000; i_radius = 16'hFFFF;
      tick();
      i_start = 1'b0;
      i_valid = 1'b1; i_ped = 32'h0000_0001; tick();
      i_ped = 32'h0000_0002; tick();
      i_valid = 1'b0;
      q = '{16'h0900};
      run_level("restart", 16'h0200, 16'h0800, q, 1, 0, 1);
      chk("restart.spec_idx", o_best_idx, 0);
      chk("restart.spec_count", o_count, 0);

      // Random levels, sometimes back-to-back with i_start during DONE
      for (int r = 0; r < 80; r++) begin
         n = $urandom_range(1, NCAND);
         use_last = 1'b1;
         if (n == NCAND && $urandom_range(1) == 1) use_last = 1'b0;
         par = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(16'h3000));
         rad = 16'($urandom);
         q = {};
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(4) == 0) q.push_back(16'($urandom));
            else                        q.push_back(16'($urandom_range(16'h2000)));
         end
         run_level("rand", par, rad, q, use_last, 30, 1'($urandom_range(1)));
         if ($urandom_range(1) == 1) begin
            tick();
            chk("rand.idle_valid", o_valid, 0);
            chk("rand.hold_dist", o_best_dist, last_dist);
            chk("rand.hold_count", o_count, last_cnt);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ped_min_select.md
# ped_min_select

Survivor selector for the sphere-decoder tree search. It receives the stream of partial Euclidean distances produced for the candidate constellation points of one tree level. It adds the parent node's accumulated distance to each, prunes against the current sphere radius, and reports the best child index and distance plus the survivor count. It sits directly downstream of the PED stage and upstream of the tree-search controller.

## Interface
Parameters:
- INT_W, 6, integer bits of the distance format
- FRAC_W, 10, fractional bits of the distance format
- WIDTH, INT_W+FRAC_W, distance word width (unsigned Q INT_W.FRAC_W)
- NCAND, 8, maximum candidates per level
- IDX_W, 3, candidate index width (≥ clog2(NCAND))
- CNT_W, IDX_W+1, survivor count width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  single-cycle pulse: begin a new level
- i_parent_dist  in  WIDTH  accumulated distance of parent node, sampled on i_start
- i_radius  in  WIDTH  sphere radius squared, sampled on i_start
- i_valid  in  1  i_ped carries one candidate distance
- i_ped  in  WIDTH*2  PED word; distance in [WIDTH-1:0], [WIDTH*2-1:WIDTH] ignored
- i_last  in  1  qualifies i_valid: final candidate of the level
- o_busy  out  1  high while collecting
- o_valid  out  1  one-cycle pulse: results below are new
- o_best_idx  out  IDX_W  arrival index (0-based) of the minimum total distance
- o_best_dist  out  WIDTH  minimum total distance
- o_count  out  CNT_W  number of candidates with total < radius
- o_found  out  1  o_count != 0

## Operation
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - i_start: latch parent and radius; best_dist ← all ones; best_idx, idx, count ← 0; go to COLLECT.
  - i_valid ignored.
- COLLECT (o_busy=1), per accepted i_valid:
  - total = parent + i_ped[WIDTH-1:0], computed WIDTH+1 bits wide; if bit WIDTH set, saturate to 2^WIDTH−1.
  - total < radius (strict): count++.
  - total < best_dist (strict; ties keep earlier index): best_dist ← total, best_idx ← idx.
  - idx++.
- COLLECT exit:
  - Go to DONE when the accepted candidate has i_last=1, or when idx == NCAND−1 at acceptance (auto-terminate).
  - i_start in COLLECT abandons the level and restarts as from IDLE (i_valid in the same cycle is ignored).
  - Cycles without i_valid: hold state.
- DONE (one cycle):
  - o_valid=1; outputs carry the final values; i_valid ignored.
  - Next state is IDLE, or COLLECT if i_start is asserted.
- Outputs o_best_idx, o_best_dist, o_count, o_found are registered, updated only on entry to DONE, and held until the next DONE.
- A level with zero candidates is not possible; i_last always accompanies i_valid.

## Timing
- Reset values: o_busy=0, o_valid=0, o_best_idx=0, o_best_dist=0, o_count=0, o_found=0; FSM in IDLE.
- Reset is asynchronous; assertion mid-COLLECT discards the level with no o_valid.
- i_start at edge t: o_busy=1 from t+1; the first candidate is accepted at t+1 at earliest.
- Final candidate accepted at edge t: o_valid=1 and results valid during the cycle after t (latency 1); o_busy=0 in that cycle.
- Throughput: one candidate per clock; back-to-back levels need one DONE cycle between them (i_start may coincide with DONE).

## Test plan
Q6.10, WIDTH=16, 1.0=0x0400.
1. Basic level:
   - Stimulus: i_start with parent=0x0400, radius=0x1000; peds 0x0800, 0x0200, 0x0C00, 0x0200 on consecutive cycles, i_last on the 4th.
   - Required: totals 0x0C00/0x0600/0x1000/0x0600; o_valid the cycle after the 4th; count=3 (0x1000 pruned); best_idx=1 (tie kept); best_dist=0x0600; found=1.
2. No survivors:
   - Stimulus: radius=0x0100, parent=0, peds 0x0300, 0x0200 (last).
   - Required: count=0, found=0, best_idx=1, best_dist=0x0200.
3. Saturation:
   - Stimulus: parent=0xF000, radius=0xFFFF, single ped 0x2000 with i_last.
   - Required: best_dist=0xFFFF, count=0.
4. Auto-terminate:
   - Stimulus: 8 valids with no i_last, peds descending 0x0800..0x0100 step 0x0100, parent=0, radius=0x0500.
   - Required: o_valid after the 8th; best_idx=7; best_dist=0x0100; count=4. A 9th valid is ignored.
5. Reset and gaps:
   - Stimulus: i_valid gaps inside a level, then assert i_rst after 2 candidates.
   - Required: no o_valid; all outputs 0; o_busy=0 immediately.
6. Mid-level restart:
   - Stimulus: 2 candidates, then i_start with a new parent/radius, then 1 candidate with i_last.
   - Required: only the post-restart candidate is counted; best_idx=0.
